// File: rtl/int_sequencer.sv
// Interrupt sequencer: edge-latches 32 sources, picks the lowest unmasked one,
// handshakes with the pipeline, then writes EPC/Cause/Status and redirects fetch.
module int_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          EPC_IDX      = 14,
  parameter int          CAUSE_IDX    = 13,
  parameter int          STATUS_IDX   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq,
  input  logic [31:0] status_in,
  input  logic [31:0] epc_in,
  input  logic        int_ack,
  input  logic        eret,
  output logic        int_req,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] pending
);

  typedef enum logic [2:0] {
    IDLE, REQ, WR_EPC, WR_CAUSE, WR_STATUS, JUMP, IN_SVC, RESTORE
  } state_t;

  localparam logic [4:0] EPC_A    = 5'(EPC_IDX);
  localparam logic [4:0] CAUSE_A  = 5'(CAUSE_IDX);
  localparam logic [4:0] STATUS_A = 5'(STATUS_IDX);

  state_t      state, nxt;
  logic [31:0] irq_q, sel, epc_q, st_q;
  logic [4:0]  idx;
  logic [31:0] rise, clr, valids, onehot;
  logic [4:0]  enc;

  assign rise   = irq & ~irq_q;
  assign valids = pending & ~status_in;
  assign clr    = (state == REQ && int_ack) ? sel : 32'd0;

  // Lowest set bit wins; the encoder only has to find the single hot bit.
  always_comb begin
    onehot = valids & (~valids + 32'd1);
    enc    = 5'd0;
    for (int i = 0; i < 32; i++)
      if (onehot[i]) enc = 5'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_q   <= '0;
      pending <= '0;
      sel     <= '0;
      idx     <= '0;
      epc_q   <= '0;
      st_q    <= '0;
    end else begin
      state   <= nxt;
      irq_q   <= irq;
      // A new rise on the bit being cleared must survive, so set wins.
      pending <= (pending & ~clr) | rise;
      if (state == IDLE && |valids) begin
        sel <= onehot;
        idx <= enc;
      end
      if (state == REQ && int_ack) begin
        epc_q <= epc_in;
        st_q  <= status_in;
      end
    end
  end

  always_comb begin
    nxt         = state;
    int_req     = 1'b0;
    cp0_we      = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    busy        = (state != IDLE);
    case (state)
      IDLE:      if (|valids) nxt = REQ;
      REQ: begin
        int_req = 1'b1;
        if (int_ack) nxt = WR_EPC;
      end
      WR_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = EPC_A;
        cp0_wdata = epc_q;
        nxt       = WR_CAUSE;
      end
      WR_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = CAUSE_A;
        cp0_wdata = {25'd0, idx, 2'b00};
        nxt       = WR_STATUS;
      end
      WR_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = STATUS_A;
        cp0_wdata = st_q | sel;
        nxt       = JUMP;
      end
      JUMP: begin
        redirect    = 1'b1;
        redirect_pc = HANDLER_ADDR;
        nxt         = IN_SVC;
      end
      IN_SVC:    if (eret) nxt = RESTORE;
      RESTORE: begin
        cp0_we    = 1'b1;
        cp0_waddr = STATUS_A;
        cp0_wdata = status_in & ~sel;
        nxt       = IDLE;
      end
      default:   nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: a per-cycle vector table for the basic
// service flow, then hand-written sequences for the multi-cycle corner cases.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq, status_in, epc_in;
  logic        int_ack, eret;
  logic        int_req, cp0_we, redirect, busy;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata, redirect_pc, pending;

  int checks = 0;
  int errors = 0;

  int_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .status_in(status_in), .epc_in(epc_in),
    .int_ack(int_ack), .eret(eret), .int_req(int_req), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] irq, status, epc;
    logic        ack, eret;
    logic        e_req, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rd;
    logic [31:0] e_pc;
    logic        e_busy;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  // Inputs are applied just after an edge; outputs are sampled 1 time unit
  // after the next edge, so each row checks the state that its inputs produced.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] s, input logic [31:0] e,
                       input logic a, input logic r);
    irq = i; status_in = s; epc_in = e; int_ack = a; eret = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t row(logic r, logic [31:0] i, logic [31:0] s, logic [31:0] e,
                               logic a, logic er, logic q, logic we, logic [4:0] ad,
                               logic [31:0] d, logic rd, logic [31:0] pc, logic b,
                               logic [31:0] p);
    vec_t v;
    v.rst_n = r; v.irq = i; v.status = s; v.epc = e; v.ack = a; v.eret = er;
    v.e_req = q; v.e_we = we; v.e_addr = ad; v.e_data = d; v.e_rd = rd;
    v.e_pc = pc; v.e_busy = b; v.e_pend = p;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    //         rst irq      stat   epc     ack er  req we addr  data      rd pc       busy pend
    tbl.push_back(row(0, 32'h0, 32'h0, 32'h0,   0, 0,  0, 0, 5'd0,  32'h0,    0, 32'h0,    0, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  0, 0, 5'd0,  32'h0,    0, 32'h0,    0, 32'h8));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  1, 0, 5'd0,  32'h0,    0, 32'h0,    1, 32'h8));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  1, 0, 5'd0,  32'h0,    0, 32'h0,    1, 32'h8));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h400, 1, 0,  0, 1, 5'd14, 32'h400,  0, 32'h0,    1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  0, 1, 5'd13, 32'hC,    0, 32'h0,    1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  0, 1, 5'd12, 32'h8,    0, 32'h0,    1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  0, 0, 5'd0,  32'h0,    1, 32'h4180, 1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   1, 0,  0, 0, 5'd0,  32'h0,    0, 32'h0,    1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 1,  0, 1, 5'd12, 32'h0,    0, 32'h0,    1, 32'h0));
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   0, 0,  0, 0, 5'd0,  32'h0,    0, 32'h0,    0, 32'h0));
    // eret and int_ack while idle with nothing pending are ignored
    tbl.push_back(row(1, 32'h8, 32'h0, 32'h0,   1, 1,  0, 0, 5'd0,  32'h0,    0, 32'h0,    0, 32'h0));
    tbl.push_back(row(1, 32'h0, 32'h0, 32'h0,   1, 1,  0, 0, 5'd0,  32'h0,    0, 32'h0,    0, 32'h0));

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n;
      drive(tbl[k].irq, tbl[k].status, tbl[k].epc, tbl[k].ack, tbl[k].eret);
      tick();
      checks++;
      if ({int_req, cp0_we, cp0_waddr, cp0_wdata, redirect, redirect_pc, busy, pending} !==
          {tbl[k].e_req, tbl[k].e_we, tbl[k].e_addr, tbl[k].e_data, tbl[k].e_rd,
           tbl[k].e_pc, tbl[k].e_busy, tbl[k].e_pend}) begin
        errors++;
        $display("FAIL row%0d: got req=%0b we=%0b addr=%0d data=%08h rd=%0b pc=%08h busy=%0b pend=%08h, expected req=%0b we=%0b addr=%0d data=%08h rd=%0b pc=%08h busy=%0b pend=%08h",
                 k, int_req, cp0_we, cp0_waddr, cp0_wdata, redirect, redirect_pc, busy, pending,
                 tbl[k].e_req, tbl[k].e_we, tbl[k].e_addr, tbl[k].e_data, tbl[k].e_rd,
                 tbl[k].e_pc, tbl[k].e_busy, tbl[k].e_pend);
      end
    end

    // Simultaneous irq5/irq2 with bit 2 masked: bit 5 wins, bit 2 stays pending.
    do_reset();
    drive(32'h24, 32'h4, 32'h0, 0, 0); tick();
    chk("s2_pend", pending, 32'h24);
    tick();
    chk("s2_req", {31'd0, int_req}, 32'd1);
    drive(32'h24, 32'h4, 32'h123, 1, 0); tick();
    chk("s2_epc", cp0_wdata, 32'h123);
    chk("s2_pend_after_ack", pending, 32'h4);
    drive(32'h24, 32'h4, 32'h0, 0, 0); tick();
    chk("s2_cause", cp0_wdata, 32'h14);
    tick();
    chk("s2_status", {cp0_we, cp0_waddr, cp0_wdata[25:0]}, {1'b1, 5'd12, 26'h24});
    tick(); tick();
    chk("s2_insvc_busy", {30'd0, busy, int_req}, 32'h2);
    drive(32'h24, 32'h21, 32'h0, 0, 1); tick();
    chk("s2_restore", cp0_wdata, 32'h1);
    drive(32'h24, 32'h21, 32'h0, 0, 0); tick();
    chk("s2_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("s2_req2", {31'd0, int_req}, 32'd1);
    drive(32'h24, 32'h21, 32'h0, 1, 0); tick();
    drive(32'h24, 32'h21, 32'h0, 0, 0); tick();
    chk("s2_cause2", cp0_wdata, 32'h8);

    // irq7 rises while in service: no request until eret and restore finish.
    tick(); tick(); tick();
    drive(32'hA4, 32'h0, 32'h0, 0, 0); tick();
    chk("s3_pend", pending, 32'h80);
    tick();
    chk("s3_no_req", {31'd0, int_req}, 32'd0);
    drive(32'hA4, 32'h0, 32'h0, 0, 1); tick();
    chk("s3_restore_no_req", {int_req, cp0_we, 30'd0}, 32'h4000_0000);
    drive(32'hA4, 32'h0, 32'h0, 0, 0); tick();
    chk("s3_idle_no_req", {31'd0, int_req}, 32'd0);
    tick();
    chk("s3_req", {31'd0, int_req}, 32'd1);
    drive(32'hA4, 32'h0, 32'h0, 1, 0); tick();
    drive(32'hA4, 32'h0, 32'h0, 0, 0); tick();
    chk("s3_cause", cp0_wdata, 32'h1C);

    // irq0 re-rises on the ack cycle: set beats clear, a second interrupt follows.
    do_reset();
    drive(32'h1, 32'h0, 32'h0, 0, 0); tick(); tick();
    chk("s4_req", {31'd0, int_req}, 32'd1);
    drive(32'h0, 32'h0, 32'h0, 0, 0); tick();
    drive(32'h1, 32'h0, 32'h50, 1, 0); tick();
    chk("s4_pend_kept", pending, 32'h1);
    drive(32'h1, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(32'h1, 32'h0, 32'h0, 0, 1); tick();
    drive(32'h1, 32'h0, 32'h0, 0, 0); tick(); tick();
    chk("s4_second_req", {31'd0, int_req}, 32'd1);

    // Highest source: Cause wraps into the top of the field.
    do_reset();
    drive(32'h8000_0000, 32'h0, 32'h0, 0, 0); tick(); tick();
    drive(32'h8000_0000, 32'h0, 32'h0, 1, 0); tick();
    drive(32'h8000_0000, 32'h0, 32'h0, 0, 0); tick();
    chk("s5_cause31", cp0_wdata, 32'h7C);
    tick();
    chk("s5_status31", cp0_wdata, 32'h8000_0000);

    // Reset during WR_CAUSE aborts the sequence with no Status write.
    do_reset();
    drive(32'h10, 32'h0, 32'h0, 0, 0); tick(); tick();
    drive(32'h10, 32'h0, 32'h0, 1, 0); tick();
    drive(32'h10, 32'h0, 32'h0, 0, 0); tick();
    chk("s6_in_cause", {27'd0, cp0_waddr}, 32'd13);
    rst_n = 1'b0; drive(32'h0, 32'h0, 32'h0, 0, 0); tick();
    chk("s6_rst_outs", {29'd0, cp0_we, int_req, busy}, 32'd0);
    chk("s6_rst_pend", pending, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s6_no_write", {30'd0, cp0_we, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
